// File: rtl/fft_arb_pkg.sv
// Shared types and defaults for the fft_arbiter slice: controller states and
// the default frame and core-latency parameters.
package fft_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  localparam int CORE_CYCLES_DEF = 4;
  localparam int FRAME_W         = 128;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or above ptr
// (with wrap) wins, and is reported one-hot and as an encoded index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // NOTE: every output gets a default before the search loop, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    int k;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && req[k]) begin
        gnt[k] = 1'b1;
        idx    = IW'(k);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fft_arbiter.sv
// Shares one 8-point fft core among NREQ requesters: round-robin grant, a
// fixed CORE_CYCLES start window, result capture and a tagged response.
// Build option FFT_ARB_STATS_EN adds the jobs_done / stall_cycles counters.
module fft_arbiter
  import fft_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int DW          = FRAME_W,
  parameter int CORE_CYCLES = CORE_CYCLES_DEF,
  parameter int IDW         = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_xr,
  input  logic [NREQ*DW-1:0] req_xi,
  output logic               core_start,
  output logic [DW-1:0]      core_xr,
  output logic [DW-1:0]      core_xi,
  input  logic [DW-1:0]      core_out_r,
  input  logic [DW-1:0]      core_out_i,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DW-1:0]      res_r,
  output logic [DW-1:0]      res_i,
  output logic [IDW-1:0]     res_id,
  output logic               busy
`ifdef FFT_ARB_STATS_EN
  ,
  output logic [15:0]        jobs_done,
  output logic [15:0]        stall_cycles
`endif
);

  localparam int CW = $clog2(CORE_CYCLES + 1);

  arb_state_t     state, state_nx;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] owner;
  logic [CW-1:0]  run_cnt;
  logic           run_last;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic            grant_fire;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IDW)
  ) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign grant_fire = (state == IDLE) && gnt_any;
  assign run_last   = (run_cnt == CW'(CORE_CYCLES - 1));

  // Outputs decode straight from state so an async reset clears them at once;
  // the grant is additionally masked while reset is held.
  assign req_ready  = (grant_fire && !rst) ? gnt : '0;
  assign core_start = (state == RUN);
  assign res_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (gnt_any) state_nx = RUN;
      RUN:     if (run_last) state_nx = CAPTURE;
      CAPTURE: state_nx = RESP;
      RESP:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the frame and result registers are reset too, because all outputs
  // must read zero after reset, not just the control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      run_cnt <= '0;
      core_xr <= '0;
      core_xi <= '0;
      res_r   <= '0;
      res_i   <= '0;
      res_id  <= '0;
    end else begin
      state <= state_nx;
      if (grant_fire) begin
        core_xr <= req_xr[int'(gnt_idx)*DW +: DW];
        core_xi <= req_xi[int'(gnt_idx)*DW +: DW];
        owner   <= gnt_idx;
        rr_ptr  <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
      end
      if (state == RUN) begin
        run_cnt <= run_last ? '0 : run_cnt + CW'(1);
      end
      // The core result is valid only on the cycle after the last start-high cycle.
      if (state == CAPTURE) begin
        res_r  <= core_out_r;
        res_i  <= core_out_i;
        res_id <= owner;
      end
    end
  end

`ifdef FFT_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jobs_done    <= '0;
      stall_cycles <= '0;
    end else begin
      if (res_valid && res_ready && jobs_done != 16'hFFFF) begin
        jobs_done <= jobs_done + 16'd1;
      end
      if (res_valid && !res_ready && stall_cycles != 16'hFFFF) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fft_arbiter.sv
// Directed self-checking bench for fft_arbiter with a small behavioural core
// whose result is valid only on the cycle after the 4th start-high cycle.
module tb_fft_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 128;
  localparam int IDW  = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_xr;
  logic [NREQ*DW-1:0] req_xi;
  logic               core_start;
  logic [DW-1:0]      core_xr;
  logic [DW-1:0]      core_xi;
  logic [DW-1:0]      core_out_r;
  logic [DW-1:0]      core_out_i;
  logic               res_valid;
  logic               res_ready;
  logic [DW-1:0]      res_r;
  logic [DW-1:0]      res_i;
  logic [IDW-1:0]     res_id;
  logic               busy;
`ifdef FFT_ARB_STATS_EN
  logic [15:0]        jobs_done;
  logic [15:0]        stall_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fft_arbiter #(
    .NREQ        (NREQ),
    .DW          (DW),
    .CORE_CYCLES (4),
    .IDW         (IDW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_xr       (req_xr),
    .req_xi       (req_xi),
    .core_start   (core_start),
    .core_xr      (core_xr),
    .core_xi      (core_xi),
    .core_out_r   (core_out_r),
    .core_out_i   (core_out_i),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_r        (res_r),
    .res_i        (res_i),
    .res_id       (res_id),
    .busy         (busy)
`ifdef FFT_ARB_STATS_EN
    ,
    .jobs_done    (jobs_done),
    .stall_cycles (stall_cycles)
`endif
  );

  // Behavioural core: stages advance only while start is high.
  logic [2:0] scnt;
  logic       ovalid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt   <= 3'd0;
      ovalid <= 1'b0;
    end else begin
      ovalid <= core_start && (scnt == 3'd3);
      if (core_start) scnt <= (scnt == 3'd3) ? 3'd0 : scnt + 3'd1;
    end
  end
  assign core_out_r = ovalid ? ~core_xr : {8{16'hBAD0}};
  assign core_out_i = ovalid ? core_xi + 128'd1 : {8{16'hBAD1}};

  function automatic logic [DW-1:0] frame_r(input int k);
    logic [7:0] b;
    b = 8'hA0 + 8'(k);
    return {16{b}};
  endfunction

  function automatic logic [DW-1:0] frame_i(input int k);
    logic [7:0] b;
    b = 8'h30 + 8'(k);
    return {16{b}};
  endfunction

  function automatic int oh2idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    if ($countones(v) == 1)
      for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Samples, then ticks, until res_valid or a 20-cycle budget runs out.
  task automatic wait_valid(output int cyc, output int starts, output int grants);
    cyc = 0; starts = 0; grants = 0;
    while (cyc < 20) begin
      if (core_start) starts++;
      if (req_ready != '0) grants++;
      if (res_valid) break;
      tick();
      cyc++;
    end
  endtask

  task automatic do_job(input int k, input int stall, output logic [IDW-1:0] id,
                        output logic [DW-1:0] r);
    int c, s, g;
    req_valid = NREQ'(1) << k;
    res_ready = (stall == 0);
    #1;
    wait_valid(c, s, g);
    req_valid = '0;
    id = res_id;
    r  = res_r;
    repeat (stall) tick();
    res_ready = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, st, gr, ng, n;
    int gidx[5];
    int gcyc[5];
    logic [DW-1:0]  r0, r;
    logic [IDW-1:0] id0, id;
    logic stable, nostart, nogrant, seen;

    rst = 1'b1; req_valid = '1; res_ready = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      req_xr[k*DW +: DW] = frame_r(k);
      req_xi[k*DW +: DW] = frame_i(k);
    end
    #2;
    check("rst_req_ready", DW'(req_ready), '0);
    check("rst_core_start", DW'(core_start), '0);
    check("rst_res_valid", DW'(res_valid), '0);
    check("rst_busy", DW'(busy), '0);
    check("rst_core_xr", core_xr, '0);
    check("rst_res_r", res_r, '0);
    check("rst_res_id", DW'(res_id), '0);
    req_valid = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Single request with an impulse frame on requester 1.
    req_xr[1*DW +: DW] = 128'h1000;
    req_valid = 4'b0010; res_ready = 1'b1;
    #1;
    check("t1_grant", DW'(req_ready), DW'(4'b0010));
    wait_valid(cyc, st, gr);
    check("t1_latency", DW'(cyc), DW'(6));
    check("t1_start_cycles", DW'(st), DW'(4));
    check("t1_grant_pulses", DW'(gr), DW'(1));
    check("t1_core_xr", core_xr, 128'h1000);
    check("t1_res_id", DW'(res_id), DW'(1));
    check("t1_res_r", res_r, ~128'h1000);
    check("t1_res_i", res_i, frame_i(1) + 128'd1);
    req_valid = '0;
    tick();
    req_xr[1*DW +: DW] = frame_r(1);

    // Strict rotation with all requesters valid, starting from rr_ptr=0.
    rst = 1'b1; #1; tick(); rst = 1'b0; tick();
    for (int i = 0; i < 5; i++) begin gidx[i] = -1; gcyc[i] = -1; end
    ng = 0;
    req_valid = 4'hF; res_ready = 1'b1;
    #1;
    for (int c = 0; c < 45 && ng < 5; c++) begin
      if (req_ready != '0) begin
        gidx[ng] = oh2idx(req_ready);
        gcyc[ng] = c;
        ng++;
      end
      tick();
    end
    req_valid = '0;
    check("rot_count", DW'(ng), DW'(5));
    for (int i = 0; i < 5; i++) check($sformatf("rot_order%0d", i), DW'(gidx[i]), DW'(i % NREQ));
    for (int i = 1; i < 5; i++) check($sformatf("rot_gap%0d", i), DW'(gcyc[i] - gcyc[i-1]), DW'(7));
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    check("rot_idle", DW'(busy), '0);

    // Backpressure: rr_ptr is now 1, so requester 2 wins.
    req_valid = 4'b0100; res_ready = 1'b0;
    #1;
    check("bp_grant", DW'(req_ready), DW'(4'b0100));
    tick();
    req_valid = 4'hF;
    wait_valid(cyc, st, gr);
    check("bp_latency", DW'(cyc), DW'(5));
    check("bp_no_grant_run", DW'(gr), '0);
    r0 = res_r; id0 = res_id;
    check("bp_res_id", DW'(id0), DW'(2));
    check("bp_res_r", r0, ~frame_r(2));
    stable = 1'b1; nostart = 1'b1; nogrant = 1'b1;
    repeat (10) begin
      tick();
      stable  &= res_valid && (res_r === r0) && (res_id === id0);
      nostart &= !core_start;
      nogrant &= (req_ready == '0);
    end
    check("bp_stable", DW'(stable), DW'(1));
    check("bp_core_idle", DW'(nostart), DW'(1));
    check("bp_no_grant", DW'(nogrant), DW'(1));
    res_ready = 1'b1;
    #1;
    check("bp_valid_held", DW'(res_valid), DW'(1));
    tick();
    check("bp_released", DW'(res_valid), '0);
    check("bp_next_grant", DW'(req_ready), DW'(4'b1000));
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    wait_valid(cyc, st, gr);
    check("j3_res_id", DW'(res_id), DW'(3));
    tick();

    // Fairness wrap: rr_ptr wrapped to 0 after serving requester 3.
    req_valid = 4'b1001;
    #1;
    check("wrap_grant", DW'(req_ready), DW'(4'b0001));
    tick();
    req_valid = '0;
    tick();
    check("mid_run_start", DW'(core_start), DW'(1));

    // Reset on the 2nd RUN cycle discards the job.
    #1;
    rst = 1'b1; req_valid = 4'hF;
    #1;
    check("mrst_core_start", DW'(core_start), '0);
    check("mrst_busy", DW'(busy), '0);
    check("mrst_req_ready", DW'(req_ready), '0);
    check("mrst_core_xr", core_xr, '0);
    check("mrst_res_r", res_r, '0);
    check("mrst_res_id", DW'(res_id), '0);
    req_valid = '0;
    repeat (2) tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin tick(); seen |= res_valid; end
    check("mrst_no_resp", DW'(seen), '0);
    do_job(2, 0, id, r);
    check("post_rst_id", DW'(id), DW'(2));
    check("post_rst_res_r", r, ~frame_r(2));

`ifdef FFT_ARB_STATS_EN
    do_job(1, 5, id, r);
    do_job(3, 0, id, r);
    check("stats_jobs", DW'(jobs_done), DW'(3));
    check("stats_stalls", DW'(stall_cycles), DW'(5));
    force dut.jobs_done = 16'hFFFE;
    force dut.stall_cycles = 16'hFFFE;
    #1;
    release dut.jobs_done;
    release dut.stall_cycles;
    do_job(0, 3, id, r);
    check("stats_jobs_sat", DW'(jobs_done), DW'(16'hFFFF));
    check("stats_stalls_sat", DW'(stall_cycles), DW'(16'hFFFF));
    do_job(1, 0, id, r);
    check("stats_jobs_hold", DW'(jobs_done), DW'(16'hFFFF));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_arbiter.md
Name: fft_arbiter

Overview:
- Shares one 8-point fft core among NREQ independent requesters.
- Arbitration is round-robin. The block latches the granted frame and sequences the core's start line for exactly CORE_CYCLES cycles.
- It captures the core's result and returns it to the requester, tagged with that requester's index.
- Sits between the per-channel frame buffers and the single fft instance. It is the only driver of the core's start and data inputs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 128, flattened frame width per component (8 x 16-bit).
- CORE_CYCLES, 4, consecutive start-high cycles the core needs: load, stage 1, stage 2, stage 3/output.
- IDW, 3, width of the requester index (at least clog2(NREQ)).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  per-requester frame pending.
- req_ready  out  NREQ  one-hot grant pulse; the frame is consumed on this cycle.
- req_xr  in  NREQ*DW  real frames; requester k occupies bits [k*DW +: DW].
- req_xi  in  NREQ*DW  imaginary frames, same packing.
- core_start  out  1  start line to the fft core.
- core_xr  out  DW  latched real operand to the core.
- core_xi  out  DW  latched imaginary operand to the core.
- core_out_r  in  DW  core real result.
- core_out_i  in  DW  core imaginary result.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_r  out  DW  captured real result.
- res_i  out  DW  captured imaginary result.
- res_id  out  IDW  requester index that owns the result.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset values: all outputs 0, state=IDLE, rr_ptr=0, run counter=0.
- Core contract:
  - The core's stage sequence advances only while core_start=1.
  - core_out_r/core_out_i are valid on the cycle after the CORE_CYCLES-th start-high cycle.
  - The core's own done flag is sticky, so this block never uses it.
  - core_start must drop for at least 1 cycle between jobs.
- State IDLE:
  - If any req_valid is set, grant the first set bit searching from rr_ptr upward with wrap.
  - Grant cycle actions: req_ready[g]=1 for this cycle only; latch req_xr/req_xi slice g into core_xr/core_xi; latch g into the owner register; rr_ptr <= (g+1) mod NREQ.
  - Next state RUN.
- State RUN:
  - core_start=1; the counter increments from 0.
  - After CORE_CYCLES cycles, go to CAPTURE.
  - core_xr/core_xi are held stable throughout RUN.
- State CAPTURE:
  - core_start=0.
  - res_r/res_i <= core_out_r/core_out_i; res_id <= owner.
  - Next state RESP.
- State RESP:
  - res_valid=1; res_r, res_i and res_id are held stable.
  - On res_valid && res_ready, go to IDLE with res_valid=0.
- Throughput and latency:
  - Best case is one job per CORE_CYCLES+3 cycles: grant, run, capture, 1 response cycle.
  - Grant to res_valid is CORE_CYCLES+2 cycles.
- Boundary conditions:
  - No grants are issued outside IDLE. req_valid may change freely at any time.
  - A requester that drops req_valid before it is granted is simply skipped.
  - With all NREQ requesters valid and res_ready=1, grants are g=0,1,...,NREQ-1,0 (strict rotation).
  - Only one requester valid: it is granted on every IDLE visit regardless of rr_ptr.
  - res_ready held low stalls the block in RESP indefinitely; the core stays idle with core_start=0.
  - rst mid-RUN: core_start drops immediately and the job is discarded without any response. The core shares rst, so it also returns to its load stage.
  - Bits of req_valid at index NREQ or above do not exist; rr_ptr never exceeds NREQ-1.

Optional Feature:
- Macro FFT_ARB_STATS_EN.
- Defined:
  - Adds output jobs_done (16 bit): increments on each res handshake and saturates at 16'hFFFF.
  - Adds output stall_cycles (16 bit): increments each cycle with res_valid && !res_ready and saturates at 16'hFFFF.
  - Both counters reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fft_arb_pkg holds:
  - state enum IDLE/RUN/CAPTURE/RESP (2-bit encoding);
  - default CORE_CYCLES=4;
  - FRAME_W=128.
- Sub-module rr_arbiter (req vector, pointer -> one-hot grant plus encoded index). It is combinational and reusable by other shared-resource controllers.
- All sequencing stays in fft_arbiter.

Test Plan:
- Single request: req_valid=4'b0010, impulse frame (xr lane0=16'h1000, other lanes 0), res_ready=1.
  - Expect req_ready=4'b0010 for 1 cycle.
  - Expect core_start high exactly 4 cycles.
  - Expect res_valid 6 cycles after the grant, res_id=1, res_r equal to the core output sampled in CAPTURE.
- All four requesters valid continuously, res_ready=1: grant order 0,1,2,3,0, one grant every 7 cycles.
- Backpressure: hold res_ready=0 for 10 cycles in RESP.
  - res_valid, res_r and res_id stay stable; core_start=0; no new grant.
  - After res_ready=1: one handshake, then the next grant.
- Fairness wrap: finish a job for requester 3, then assert req_valid=4'b1001; the next grant is 0 because rr_ptr wrapped to 0.
- Reset mid-RUN: assert rst on the 2nd RUN cycle.
  - All outputs go to 0 asynchronously; no res_valid ever appears for that job.
  - After release, a new request completes normally.
- With FFT_ARB_STATS_EN: after 3 jobs and 5 stall cycles, jobs_done=3 and stall_cycles=5. A preload near saturation stays at 16'hFFFF.
